mult_div_unit: RTL and testbench

- Multicycle signed multiply/divide responder for the MIPS datapath. Serves the control unit's MULT_on/DIV_on requests.
- The control unit pulses a start, stalls on busy, and sees done. It then copies hi/lo into the Hi/Lo registers (Hi_write/Lo_write).
- A divide-by-zero is reported on div_zero, which feeds the control unit's dzero exception path.
- Operands come from the A/B register outputs.

---
 rtl/mult_div_if.sv | 25 ++
 rtl/mult_div_unit.sv | 146 ++++++++++++++
 tb/tb_mult_div_unit.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mult_div_if.sv
// Request/response bundle between the control unit and the multiply/divide unit.
// The master drives the operands and start strobes; the slave returns the results and status.
interface mult_div_if #(
    parameter int unsigned WIDTH = 32
);
    logic             mult_start;
    logic             div_start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output mult_start, div_start, a, b,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  mult_start, div_start, a, b,
        output hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) and divide (restoring, on magnitudes).
// Each operation writes its result to hi/lo and pulses done.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    mult_div_if.slave  bus
);
    localparam int unsigned CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MULT,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state;
    logic             op_div;
    logic             neg_q;
    logic             neg_r;
    logic             q_1;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] mq;
    logic [WIDTH:0]   acc;

    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_sub;
    logic             rem_ge;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    // acc is kept sign-extended to W+1 bits so the Booth add cannot overflow.
    always_comb begin
        booth_sum = acc;
        case ({mq[0], q_1})
            2'b01:   booth_sum = acc + {m[WIDTH-1], m};
            2'b10:   booth_sum = acc - {m[WIDTH-1], m};
            default: booth_sum = acc;
        endcase
        rem_shift = {acc[WIDTH-1:0], mq[WIDTH-1]};
        rem_sub   = rem_shift - {1'b0, m};
        rem_ge    = (rem_shift >= {1'b0, m});
        a_mag     = bus.a[WIDTH-1] ? (WIDTH'(0) - bus.a) : bus.a;
        b_mag     = bus.b[WIDTH-1] ? (WIDTH'(0) - bus.b) : bus.b;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            op_div       <= 1'b0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            q_1          <= 1'b0;
            count        <= '0;
            m            <= '0;
            mq           <= '0;
            acc          <= '0;
            bus.hi       <= '0;
            bus.lo       <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.div_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Multiply has priority when both strobes arrive together.
                    if (bus.mult_start) begin
                        op_div       <= 1'b0;
                        m            <= bus.b;
                        mq           <= bus.a;
                        acc          <= '0;
                        q_1          <= 1'b0;
                        count        <= '0;
                        bus.busy     <= 1'b1;
                        bus.div_zero <= 1'b0;
                        state        <= S_MULT;
                    end else if (bus.div_start) begin
                        bus.busy <= 1'b1;
                        if (bus.b == '0) begin
                            bus.div_zero <= 1'b1;
                            state        <= S_DONE;
                        end else begin
                            op_div       <= 1'b1;
                            m            <= b_mag;
                            mq           <= a_mag;
                            acc          <= '0;
                            neg_q        <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                            neg_r        <= bus.a[WIDTH-1];
                            count        <= '0;
                            bus.div_zero <= 1'b0;
                            state        <= S_DIV;
                        end
                    end
                end
                S_MULT: begin
                    acc   <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                    mq    <= {booth_sum[0], mq[WIDTH-1:1]};
                    q_1   <= mq[0];
                    count <= count + CW'(1);
                    if (count == LAST) state <= S_FIX;
                end
                S_DIV: begin
                    if (rem_ge) begin
                        acc <= rem_sub;
                        mq  <= {mq[WIDTH-2:0], 1'b1};
                    end else begin
                        acc <= rem_shift;
                        mq  <= {mq[WIDTH-2:0], 1'b0};
                    end
                    count <= count + CW'(1);
                    if (count == LAST) state <= S_FIX;
                end
                S_FIX: begin
                    if (op_div) begin
                        bus.lo <= neg_q ? (WIDTH'(0) - mq) : mq;
                        bus.hi <= neg_r ? (WIDTH'(0) - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
                    end else begin
                        bus.hi <= acc[WIDTH-1:0];
                        bus.lo <= mq;
                    end
                    bus.div_zero <= 1'b0;
                    bus.busy     <= 1'b0;
                    bus.done     <= 1'b1;
                    state        <= S_DONE;
                end
                S_DONE: begin
                    // A divide-by-zero arrives here with done low and spends one cycle raising it.
                    if (bus.done) begin
                        bus.done <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: the driver queues expected results, the monitor checks on done.
module tb_mult_div_unit;
    localparam int unsigned W = 32;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    mult_div_if #(.WIDTH(W)) bus ();
    mult_div_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset === 1'b0 && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending operation");
            end else begin
                e = sb.pop_front();
                check("result_hi", 64'(bus.hi), 64'(e.hi));
                check("result_lo", 64'(bus.lo), 64'(e.lo));
                check("result_div_zero", 64'(bus.div_zero), 64'(e.dz));
                check("busy_in_done", 64'(bus.busy), 64'd0);
            end
        end
    end

    // Drive one start cycle from a negedge; returns at the negedge of cycle 1.
    task automatic start(input logic ms, input logic ds, input logic [W-1:0] av, input logic [W-1:0] bv);
        bus.mult_start = ms;
        bus.div_start  = ds;
        bus.a          = av;
        bus.b          = bv;
        @(negedge clk);
        bus.mult_start = 1'b0;
        bus.div_start  = 1'b0;
        bus.a          = ~av;
        bus.b          = ~bv;
    endtask

    task automatic wait_done(input string name, input int exp_lat, input int n0);
        int n;
        int nb;
        n  = n0;
        nb = n0 - 1;
        while (bus.done !== 1'b1 && n < 100) begin
            if (bus.busy === 1'b1) nb++;
            @(negedge clk);
            n++;
        end
        check({name, "_latency"}, 64'(n), 64'(exp_lat));
        check({name, "_busy_cycles"}, 64'(nb), 64'(exp_lat - 1));
        @(negedge clk);
    endtask

    task automatic run_op(input string name, input logic ms, input logic ds,
                          input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] ehi, input logic [W-1:0] elo,
                          input logic edz, input int lat);
        sb.push_back('{hi: ehi, lo: elo, dz: edz});
        start(ms, ds, av, bv);
        wait_done(name, lat, 1);
    endtask

    initial begin
        reset          = 1'b1;
        bus.mult_start = 1'b0;
        bus.div_start  = 1'b0;
        bus.a          = '0;
        bus.b          = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_hi", 64'(bus.hi), 64'd0);
        check("reset_lo", 64'(bus.lo), 64'd0);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_div_zero", 64'(bus.div_zero), 64'd0);

        run_op("mult_7_m3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34);
        run_op("mult_min_min", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 34);
        run_op("mult_max_max", 1'b1, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h1, 1'b0, 34);
        run_op("div_m7_2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34);
        run_op("div_7_m2", 1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 34);
        run_op("div_by_zero", 1'b0, 1'b1, 32'd5, 32'd0, 32'd1, 32'hFFFF_FFFD, 1'b1, 2);

        repeat (3) @(negedge clk);
        check("div_zero_held", 64'(bus.div_zero), 64'd1);
        check("hi_held", 64'(bus.hi), 64'd1);

        // The accept edge of the next start clears div_zero.
        sb.push_back('{hi: 32'h0, lo: 32'h8000_0000, dz: 1'b0});
        start(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_zero_cleared", 64'(bus.div_zero), 64'd0);
        wait_done("div_overflow", 34, 1);

        run_op("both_starts", 1'b1, 1'b1, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 34);
        run_op("div_100_7", 1'b0, 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34);
        run_op("div_m100_m7", 1'b0, 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd14, 1'b0, 34);

        // A div_start while busy must be ignored.
        sb.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FE0C, dz: 1'b0});
        start(1'b1, 1'b0, 32'd100, 32'hFFFF_FFFB);
        repeat (9) @(negedge clk);
        bus.div_start = 1'b1;
        bus.a         = 32'd5;
        bus.b         = 32'd0;
        @(negedge clk);
        bus.div_start = 1'b0;
        wait_done("mult_ignore_div", 34, 11);

        // Reset mid-operation: no done, outputs back to reset values.
        start(1'b1, 1'b0, 32'd3, 32'd5);
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_hi", 64'(bus.hi), 64'd0);
        check("abort_lo", 64'(bus.lo), 64'd0);
        check("abort_div_zero", 64'(bus.div_zero), 64'd0);
        repeat (40) @(negedge clk);

        run_op("mult_m1_m1", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0, 34);
        repeat (5) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
